// File: rtl/program_memory_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : prog_mem_arb_pkg
// Brief  : Shared types for the program-memory read arbiter.
// Rev    : 1.0
// ============================================================================
package prog_mem_arb_pkg;

    // The id field covers the largest supported requester count (8).
    localparam int c_max_req = 8;
    localparam int ID_W      = $clog2(c_max_req);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } arb_tag_t;

endpackage
`default_nettype wire

// File: rtl/program_memory_arbiter_rr_picker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : rr_picker
// Brief  : Combinational round-robin pick, scanning from (ptr+1) mod NUM_REQ.
// Rev    : 1.0
// ============================================================================
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_pick,
    output logic               o_any
);

    // Modulo by compare so non-power-of-two counts wrap correctly.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    always_comb begin
        o_grant = '0;
        o_pick  = '0;
        o_any   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!o_any && i_req[wrap_add(i_ptr, k)]) begin
                o_any                      = 1'b1;
                o_pick                     = wrap_add(i_ptr, k);
                o_grant[wrap_add(i_ptr, k)] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/program_memory_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : program_memory_arbiter
// Brief  : Round-robin sharing of a fixed-latency program-memory read port,
//          with tagged routing of returned words to their issuers.
// Rev    : 1.0
// ============================================================================
module program_memory_arbiter
    import prog_mem_arb_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          enable_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    output logic [NUM_REQ-1:0]            rsp_valid_out,
    output logic [DATA_WIDTH-1:0]         rsp_data_out,
    output logic [ADDR_WIDTH-1:0]         mem_addr_out,
    output logic                          mem_read_request_out,
    input  logic [DATA_WIDTH-1:0]         mem_instr_in,
    input  logic                          mem_data_valid_in,
    output logic                          busy_out,
    output logic                          orphan_err_out
);

    localparam int c_ptr_w = $clog2(NUM_REQ);
    localparam int c_tail  = READ_LATENCY - 1;

    logic [c_ptr_w-1:0]    r_ptr;
    arb_tag_t              r_tag [READ_LATENCY];
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_orphan;

    logic [NUM_REQ-1:0]    w_req;
    logic [NUM_REQ-1:0]    w_grant;
    logic [c_ptr_w-1:0]    w_pick;
    logic                  w_any;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [NUM_REQ-1:0]    w_tail_hit;
    logic [READ_LATENCY-1:0] w_stage_valid;

    assign w_req = enable_in ? req_valid_in : '0;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_ptr_w)
    ) u_picker (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_pick  (w_pick),
        .o_any   (w_any)
    );

    always_comb begin
        w_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) w_addr = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_tail_dec
        assign w_tail_hit[gi] = r_tag[c_tail].valid && (r_tag[c_tail].id == ID_W'(gi));
    end

    for (genvar gs = 0; gs < READ_LATENCY; gs++) begin : g_stage_valid
        assign w_stage_valid[gs] = r_tag[gs].valid;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ptr       <= c_ptr_w'(NUM_REQ - 1);
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_orphan    <= 1'b0;
            for (int s = 0; s < READ_LATENCY; s++) r_tag[s] <= '0;
        end else begin
            if (w_any) r_ptr <= w_pick;

            r_tag[0] <= '{valid: w_any, id: ID_W'(w_pick)};
            for (int s = 1; s < READ_LATENCY; s++) r_tag[s] <= r_tag[s-1];

            // Tail with no returned word simply expires: that response is lost.
            r_rsp_valid <= mem_data_valid_in ? w_tail_hit : '0;
            if (mem_data_valid_in && r_tag[c_tail].valid) r_rsp_data <= mem_instr_in;
            if (mem_data_valid_in && !r_tag[c_tail].valid) r_orphan <= 1'b1;
        end
    end

    assign req_ready_out        = w_grant;
    assign mem_read_request_out = w_any;
    assign mem_addr_out         = w_addr;
    assign rsp_valid_out        = r_rsp_valid;
    assign rsp_data_out         = r_rsp_data;
    assign busy_out             = |w_stage_valid;
    assign orphan_err_out       = r_orphan;

endmodule
`default_nettype wire

// File: tb/tb_program_memory_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_program_memory_arbiter
// Brief  : Directed, table-driven bench for program_memory_arbiter.
// Rev    : 1.0
// ============================================================================
module tb_program_memory_arbiter;

    localparam int NREQ = 3;
    localparam logic [31:0] A0 = 32'h0000_0040;
    localparam logic [31:0] A1 = 32'h0000_0104;
    localparam logic [31:0] A2 = 32'h0000_0208;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [NREQ-1:0]   vld;
    logic [NREQ*32-1:0] addrs;
    logic [NREQ-1:0]   rdy;
    logic [NREQ-1:0]   rspv;
    logic [31:0]       rspd;
    logic [31:0]       maddr;
    logic              mreq;
    logic [31:0]       mdata;
    logic              mdv;
    logic              busy;
    logic              orphan;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    program_memory_arbiter #(
        .NUM_REQ      (NREQ),
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .READ_LATENCY (2)
    ) dut (
        .clk_in               (clk),
        .rst_n_in             (rst_n),
        .enable_in            (en),
        .req_valid_in         (vld),
        .req_addr_in          (addrs),
        .req_ready_out        (rdy),
        .rsp_valid_out        (rspv),
        .rsp_data_out         (rspd),
        .mem_addr_out         (maddr),
        .mem_read_request_out (mreq),
        .mem_instr_in         (mdata),
        .mem_data_valid_in    (mdv),
        .busy_out             (busy),
        .orphan_err_out       (orphan)
    );

    typedef struct {
        logic        rstn;
        logic        en;
        logic [2:0]  vld;
        logic        mdv;
        logic [31:0] mdata;
        logic [2:0]  rdy;
        logic        mreq;
        logic [31:0] maddr;
        logic [2:0]  rspv;
        logic [31:0] rspd;
        logic        busy;
        logic        orph;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rstn_i, input logic en_i, input logic [2:0] vld_i,
                       input logic mdv_i, input logic [31:0] mdata_i,
                       input logic [2:0] rdy_i, input logic mreq_i, input logic [31:0] maddr_i,
                       input logic [2:0] rspv_i, input logic [31:0] rspd_i,
                       input logic busy_i, input logic orph_i);
        vec_t v;
        v.rstn = rstn_i; v.en = en_i; v.vld = vld_i; v.mdv = mdv_i; v.mdata = mdata_i;
        v.rdy = rdy_i; v.mreq = mreq_i; v.maddr = maddr_i; v.rspv = rspv_i;
        v.rspd = rspd_i; v.busy = busy_i; v.orph = orph_i;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 ns later.
    task automatic drive(input logic rstn_i, input logic en_i, input logic [2:0] vld_i,
                         input logic mdv_i, input logic [31:0] mdata_i);
        @(negedge clk);
        rst_n = rstn_i; en = en_i; vld = vld_i; mdv = mdv_i; mdata = mdata_i;
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        addrs = {A2, A1, A0};
        rst_n = 1'b0; en = 1'b0; vld = '0; mdv = 1'b0; mdata = '0;

        //  rstn en vld    mdv mdata          rdy    mreq maddr rspv   rspd           busy orph
        add(1, 1, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0, 3'b000, 32'h0,        0, 0); // 0 reset state
        add(1, 1, 3'b001, 0, 32'h0,        3'b001, 1, A0,    3'b000, 32'h0,        0, 0); // 1 single req0
        add(1, 1, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0, 3'b000, 32'h0,        1, 0); // 2
        add(1, 1, 3'b000, 1, 32'hDEADBEEF, 3'b000, 0, 32'h0, 3'b000, 32'h0,        1, 0); // 3
        add(1, 1, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0, 3'b001, 32'hDEADBEEF, 0, 0); // 4
        add(0, 1, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0, 3'b000, 32'h0,        0, 0); // 5 reset
        add(1, 1, 3'b111, 0, 32'h0,        3'b001, 1, A0,    3'b000, 32'h0,        0, 0); // 6 all valid
        add(1, 1, 3'b111, 0, 32'h0,        3'b010, 1, A1,    3'b000, 32'h0,        1, 0); // 7
        add(1, 1, 3'b111, 1, 32'h11110000, 3'b100, 1, A2,    3'b000, 32'h0,        1, 0); // 8
        add(1, 1, 3'b111, 1, 32'h22221111, 3'b001, 1, A0,    3'b001, 32'h11110000, 1, 0); // 9
        add(1, 1, 3'b111, 1, 32'h33332222, 3'b010, 1, A1,    3'b010, 32'h22221111, 1, 0); // 10
        add(1, 1, 3'b111, 1, 32'h44443333, 3'b100, 1, A2,    3'b100, 32'h33332222, 1, 0); // 11
        add(1, 1, 3'b000, 1, 32'h55554444, 3'b000, 0, 32'h0, 3'b001, 32'h44443333, 1, 0); // 12
        add(1, 1, 3'b000, 1, 32'h66665555, 3'b000, 0, 32'h0, 3'b010, 32'h55554444, 1, 0); // 13
        add(1, 1, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0, 3'b100, 32'h66665555, 0, 0); // 14
        add(1, 1, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0, 3'b000, 32'h66665555, 0, 0); // 15 data holds
        add(1, 1, 3'b000, 1, 32'h0BADF00D, 3'b000, 0, 32'h0, 3'b000, 32'h66665555, 0, 0); // 16 orphan
        add(1, 1, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0, 3'b000, 32'h66665555, 0, 1); // 17
        add(1, 1, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0, 3'b000, 32'h66665555, 0, 1); // 18 sticky
        add(1, 1, 3'b001, 0, 32'h0,        3'b001, 1, A0,    3'b000, 32'h66665555, 0, 1); // 19 grant t
        add(1, 1, 3'b010, 0, 32'h0,        3'b010, 1, A1,    3'b000, 32'h66665555, 1, 1); // 20 grant t+1
        add(0, 1, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0, 3'b000, 32'h0,        0, 0); // 21 reset mid-flight
        add(1, 1, 3'b111, 0, 32'h0,        3'b001, 1, A0,    3'b000, 32'h0,        0, 0); // 22 req0 first
        add(1, 1, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0, 3'b000, 32'h0,        1, 0); // 23 no stale rsp
        add(1, 1, 3'b000, 1, 32'h12345678, 3'b000, 0, 32'h0, 3'b000, 32'h0,        1, 0); // 24
        add(1, 1, 3'b000, 0, 32'h0,        3'b000, 0, 32'h0, 3'b001, 32'h12345678, 0, 0); // 25

        repeat (2) @(negedge clk);

        foreach (tbl[r]) begin
            drive(tbl[r].rstn, tbl[r].en, tbl[r].vld, tbl[r].mdv, tbl[r].mdata);
            chk("ready",   r, 32'(rdy),    32'(tbl[r].rdy));
            chk("memreq",  r, 32'(mreq),   32'(tbl[r].mreq));
            chk("memaddr", r, maddr,       tbl[r].maddr);
            chk("rspv",    r, 32'(rspv),   32'(tbl[r].rspv));
            chk("rspd",    r, rspd,        tbl[r].rspd);
            chk("busy",    r, 32'(busy),   32'(tbl[r].busy));
            chk("orphan",  r, 32'(orphan), 32'(tbl[r].orph));
        end

        // Enable gating, then enable dropping with a read in flight (ptr is 0 here).
        drive(1, 0, 3'b010, 0, 32'h0);
        chk("en0_ready",  100, 32'(rdy),  32'h0);
        chk("en0_memreq", 100, 32'(mreq), 32'h0);
        chk("en0_addr",   100, maddr,     32'h0);
        drive(1, 1, 3'b010, 0, 32'h0);
        chk("en1_ready",  101, 32'(rdy),  32'(3'b010));
        chk("en1_addr",   101, maddr,     A1);
        drive(1, 0, 3'b010, 0, 32'h0);
        chk("drop_ready", 102, 32'(rdy),  32'h0);
        chk("drop_busy",  102, 32'(busy), 32'h1);
        drive(1, 0, 3'b000, 1, 32'hCAFEF00D);
        chk("drop_busy2", 103, 32'(busy), 32'h1);
        chk("drop_rspv0", 103, 32'(rspv), 32'h0);
        drive(1, 0, 3'b000, 0, 32'h0);
        chk("drop_rspv",  104, 32'(rspv), 32'(3'b010));
        chk("drop_rspd",  104, rspd,      32'hCAFEF00D);
        chk("drop_busy3", 104, 32'(busy), 32'h0);
        drive(1, 0, 3'b000, 0, 32'h0);
        chk("drop_pulse", 105, 32'(rspv), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
